// File: rtl/fmadd_norm_sequencer_if.sv
// rtl/fmadd_norm_sequencer_if.sv - operand/result handshake bundle for the FMADD normalization sequencer
// master drives operands and out_ready; slave is the sequencer.
interface fmadd_norm_sequencer_if #(
  parameter int MANT_W = 32,
  parameter int EXP_W  = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [MANT_W-1:0] in_mant;
  logic [EXP_W-1:0]  in_exp;
  logic              in_sign;

  logic              out_valid;
  logic              out_ready;
  logic [MANT_W-1:0] out_mant;
  logic [EXP_W-1:0]  out_exp;
  logic              out_sign;
  logic              out_zero;
  logic              out_uflow;

  modport master (
    output in_valid, in_mant, in_exp, in_sign, out_ready,
    input  in_ready, out_valid, out_mant, out_exp, out_sign, out_zero, out_uflow
  );

  modport slave (
    input  in_valid, in_mant, in_exp, in_sign, out_ready,
    output in_ready, out_valid, out_mant, out_exp, out_sign, out_zero, out_uflow
  );
endinterface

// File: rtl/fmadd_norm_sequencer.sv
// rtl/fmadd_norm_sequencer.sv - post-add normalization controller driving the shared LZD tree
// Optional feature: define FMADD_NORM_BYPASS_EN to let already-normalized operands skip straight to DONE.
module fmadd_norm_sequencer #(
  parameter int MANT_W = 32,
  parameter int EXP_W  = 10,
  parameter int CNT_W  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  fmadd_norm_sequencer_if.slave bus,
  output logic [MANT_W-1:0]     lzd_mant,
  input  logic [CNT_W-1:0]      lzd_cnt,
  input  logic                  lzd_val,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DETECT = 2'd1,
    SHIFT  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state, state_n;

  logic [MANT_W-1:0]       mant_q;
  logic signed [EXP_W-1:0] exp_q;
  logic                    sign_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    val_q;

  logic [MANT_W-1:0]       out_mant_q;
  logic [EXP_W-1:0]        out_exp_q;
  logic                    out_sign_q;
  logic                    out_zero_q;
  logic                    out_uflow_q;

  logic                    take_op;
  logic                    take_bypass;

  logic [MANT_W-1:0]       norm_mant;
  logic signed [EXP_W-1:0] norm_exp;
  logic                    norm_zero;
  logic                    norm_uflow;
  logic signed [EXP_W-1:0] cnt_s;
  logic [CNT_W-1:0]        clamp_shift;

`ifdef FMADD_NORM_BYPASS_EN
  logic bypass_hit;
  assign bypass_hit = bus.in_mant[MANT_W-1] && ($signed(bus.in_exp) >= EXP_W'(1));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n       = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    busy          = 1'b1;
    lzd_mant      = '0;
    take_op       = 1'b0;
    take_bypass   = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        busy         = 1'b0;
        if (bus.in_valid) begin
`ifdef FMADD_NORM_BYPASS_EN
          if (bypass_hit) begin
            take_bypass = 1'b1;
            state_n     = DONE;
          end else begin
            take_op = 1'b1;
            state_n = DETECT;
          end
`else
          take_op = 1'b1;
          state_n = DETECT;
`endif
        end
      end
      DETECT: begin
        lzd_mant = mant_q;
        state_n  = SHIFT;
      end
      SHIFT: begin
        state_n = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Exponent must stay >= 1 for a normal result; otherwise the shift is clamped and the result is denormal.
  assign cnt_s       = signed'({{(EXP_W-CNT_W){1'b0}}, cnt_q});
  assign clamp_shift = exp_q[CNT_W-1:0] - CNT_W'(1);

  always_comb begin
    norm_mant  = '0;
    norm_exp   = '0;
    norm_zero  = 1'b0;
    norm_uflow = 1'b0;
    if (!val_q) begin
      norm_zero = 1'b1;
    end else if (exp_q > cnt_s) begin
      norm_mant = mant_q << cnt_q;
      norm_exp  = exp_q - cnt_s;
    end else if (exp_q > EXP_W'(0)) begin
      norm_mant  = mant_q << clamp_shift;
      norm_uflow = 1'b1;
    end else begin
      norm_mant  = mant_q;
      norm_uflow = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mant_q      <= '0;
      exp_q       <= '0;
      sign_q      <= 1'b0;
      cnt_q       <= '0;
      val_q       <= 1'b0;
      out_mant_q  <= '0;
      out_exp_q   <= '0;
      out_sign_q  <= 1'b0;
      out_zero_q  <= 1'b0;
      out_uflow_q <= 1'b0;
    end else begin
      if (take_op) begin
        mant_q <= bus.in_mant;
        exp_q  <= bus.in_exp;
        sign_q <= bus.in_sign;
      end
      if (state == DETECT) begin
        cnt_q <= lzd_cnt;
        val_q <= lzd_val;
      end
      if (state == SHIFT) begin
        out_mant_q  <= norm_mant;
        out_exp_q   <= norm_exp;
        out_sign_q  <= sign_q;
        out_zero_q  <= norm_zero;
        out_uflow_q <= norm_uflow;
      end
      if (take_bypass) begin
        out_mant_q  <= bus.in_mant;
        out_exp_q   <= bus.in_exp;
        out_sign_q  <= bus.in_sign;
        out_zero_q  <= 1'b0;
        out_uflow_q <= 1'b0;
      end
    end
  end

  assign bus.out_mant  = out_mant_q;
  assign bus.out_exp   = out_exp_q;
  assign bus.out_sign  = out_sign_q;
  assign bus.out_zero  = out_zero_q;
  assign bus.out_uflow = out_uflow_q;

endmodule

// File: tb/tb_fmadd_norm_sequencer.sv
// tb/tb_fmadd_norm_sequencer.sv - scoreboard bench for fmadd_norm_sequencer with a behavioural LZD
module tb_fmadd_norm_sequencer;

  localparam int MANT_W = 32;
  localparam int EXP_W  = 10;
  localparam int CNT_W  = 5;

  typedef struct {
    logic [31:0] mant;
    logic [9:0]  exp;
    logic        sign;
    logic        zero;
    logic        uflow;
    int          lat;
    logic        lzd_used;
  } result_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [MANT_W-1:0] lzd_mant;
  logic [CNT_W-1:0]  lzd_cnt;
  logic              lzd_val;
  logic              busy;

  int tests_run    = 0;
  int tests_failed = 0;
  result_t sb_q[$];

  fmadd_norm_sequencer_if #(.MANT_W(MANT_W), .EXP_W(EXP_W)) bus ();

  fmadd_norm_sequencer #(.MANT_W(MANT_W), .EXP_W(EXP_W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .lzd_mant (lzd_mant),
    .lzd_cnt  (lzd_cnt),
    .lzd_val  (lzd_val),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    lzd_val = |lzd_mant;
    lzd_cnt = '0;
    for (int i = 0; i < 32; i++) begin
      if (lzd_mant[i]) lzd_cnt = 5'(31 - i);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic result_t mk(input logic [31:0] m, input logic [9:0] e, input logic s,
                                 input logic z, input logic u, input int lat, input logic used);
    result_t r;
    r.mant = m; r.exp = e; r.sign = s; r.zero = z; r.uflow = u; r.lat = lat; r.lzd_used = used;
    return r;
  endfunction

  function automatic result_t model(input logic [31:0] m, input logic signed [9:0] e, input logic s);
    result_t r;
    int lz;
    logic [31:0] t;
    r = mk(32'h0, 10'h0, s, 1'b0, 1'b0, 3, m != 0);
    if (m == 0) begin
      r.zero = 1'b1;
      return r;
    end
    t = m;
    lz = 0;
    while (!t[31]) begin
      t = t << 1;
      lz++;
    end
    if (int'(e) > lz) begin
      r.mant = m << lz;
      r.exp  = e - 10'(lz);
    end else if (int'(e) >= 1) begin
      r.mant  = m << (int'(e) - 1);
      r.uflow = 1'b1;
    end else begin
      r.mant  = m;
      r.uflow = 1'b1;
    end
`ifdef FMADD_NORM_BYPASS_EN
    if (m[31] && int'(e) >= 1) begin
      r.lat      = 1;
      r.lzd_used = 1'b0;
    end
`endif
    return r;
  endfunction

  // Drives one op, waits for the result, optionally stalls with a competing in_valid held high.
  task automatic do_op(input logic [31:0] m, input logic [9:0] e, input logic s, input result_t want,
                       input int stall, input logic intrude);
    result_t x;
    int lat;
    logic seen;
    sb_q.push_back(want);
    @(negedge clk);
    bus.in_mant   = m;
    bus.in_exp    = e;
    bus.in_sign   = s;
    bus.in_valid  = 1'b1;
    bus.out_ready = (stall == 0);
    check("in_ready_at_accept", bus.in_ready, 1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat  = 1;
    seen = 1'b0;
    @(negedge clk);
    while (!bus.out_valid && lat < 20) begin
      if (lzd_mant != 0) seen = 1'b1;
      @(negedge clk);
      lat++;
    end
    check("out_valid", bus.out_valid, 1);
    x = sb_q.pop_front();
    check("latency", lat, x.lat);
    check("lzd_driven", seen, x.lzd_used);
    check("out_mant", bus.out_mant, x.mant);
    check("out_exp", bus.out_exp, x.exp);
    check("out_sign", bus.out_sign, x.sign);
    check("out_zero", bus.out_zero, x.zero);
    check("out_uflow", bus.out_uflow, x.uflow);
    for (int i = 0; i < stall; i++) begin
      if (intrude) begin
        bus.in_mant  = 32'h0000_0001;
        bus.in_exp   = 10'd40;
        bus.in_sign  = 1'b0;
        bus.in_valid = 1'b1;
      end
      @(negedge clk);
      check("stall_valid", bus.out_valid, 1);
      check("stall_in_ready", bus.in_ready, 0);
      check("stall_busy", busy, 1);
      check("stall_mant", bus.out_mant, x.mant);
      check("stall_exp", bus.out_exp, x.exp);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("post_hs_valid", bus.out_valid, 0);
    check("post_hs_in_ready", bus.in_ready, 1);
    check("post_hs_mant_held", bus.out_mant, x.mant);
  endtask

  task automatic abort_in_shift();
    @(negedge clk);
    bus.in_mant  = 32'h00ff_0000;
    bus.in_exp   = 10'd30;
    bus.in_sign  = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    check("abort_valid", bus.out_valid, 0);
    check("abort_in_ready", bus.in_ready, 1);
    check("abort_busy", busy, 0);
    check("abort_mant", bus.out_mant, 0);
    check("abort_exp", bus.out_exp, 0);
    check("abort_sign", bus.out_sign, 0);
    check("abort_lzd", lzd_mant, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] m;
    logic [9:0]  e;
    logic        s;
    bus.in_valid  = 1'b0;
    bus.in_mant   = '0;
    bus.in_exp    = '0;
    bus.in_sign   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_mant", bus.out_mant, 0);
    check("rst_out_zero", bus.out_zero, 0);
    check("rst_out_uflow", bus.out_uflow, 0);
    rst = 1'b0;

    do_op(32'h0000_8000, 10'd100, 1'b0, mk(32'h8000_0000, 10'd84, 1'b0, 1'b0, 1'b0, 3, 1'b1), 0, 1'b0);
    do_op(32'h0000_0000, 10'd50, 1'b1, mk(32'h0, 10'd0, 1'b1, 1'b1, 1'b0, 3, 1'b0), 0, 1'b0);
    do_op(32'h0000_0100, 10'd5, 1'b0, mk(32'h0000_1000, 10'd0, 1'b0, 1'b0, 1'b1, 3, 1'b1), 0, 1'b0);
    do_op(32'h0000_0100, -10'sd3, 1'b1, mk(32'h0000_0100, 10'd0, 1'b1, 1'b0, 1'b1, 3, 1'b1), 0, 1'b0);
    do_op(32'h0000_0100, 10'd1, 1'b0, mk(32'h0000_0100, 10'd0, 1'b0, 1'b0, 1'b1, 3, 1'b1), 0, 1'b0);
    do_op(32'h0000_0100, 10'd24, 1'b0, mk(32'h8000_0000, 10'd1, 1'b0, 1'b0, 1'b0, 3, 1'b1), 0, 1'b0);

    do_op(32'h0040_0000, 10'd20, 1'b1, mk(32'h8000_0000, 10'd11, 1'b1, 1'b0, 1'b0, 3, 1'b1), 10, 1'b1);
    do_op(32'h0000_0001, 10'd40, 1'b0, mk(32'h8000_0000, 10'd9, 1'b0, 1'b0, 1'b0, 3, 1'b1), 0, 1'b0);

    abort_in_shift();
    do_op(32'h0003_0000, 10'd60, 1'b1, mk(32'hC000_0000, 10'd46, 1'b1, 1'b0, 1'b0, 3, 1'b1), 0, 1'b0);

`ifdef FMADD_NORM_BYPASS_EN
    do_op(32'h8000_0001, 10'd10, 1'b0, mk(32'h8000_0001, 10'd10, 1'b0, 1'b0, 1'b0, 1, 1'b0), 0, 1'b0);
`else
    do_op(32'h8000_0001, 10'd10, 1'b0, mk(32'h8000_0001, 10'd10, 1'b0, 1'b0, 1'b0, 3, 1'b1), 0, 1'b0);
`endif

    for (int n = 0; n < 24; n++) begin
      m = (n % 7 == 3) ? 32'h0 : (($urandom() | 32'h8000_0000) >> $urandom_range(0, 31));
      e = 10'($signed($urandom_range(0, 80)) - 20);
      s = 1'($urandom_range(0, 1));
      do_op(m, e, s, model(m, e, s), $urandom_range(0, 2), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
